// File: rtl/outqueue_pkt_gen.sv
// outqueue_pkt_gen: pops {tuple, len} entries from the info FIFO and emits one AXI-Stream packet per entry
module outqueue_pkt_gen #(
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int DATA_WIDTH      = 64,
  parameter int MIN_PKT_LEN     = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     enable,
  input  logic [PKT_TUPLE_WIDTH+PKT_LEN_WIDTH-1:0] fifo_data_in,
  input  logic                                     fifo_empty,
  output logic                                     fifo_rd_en,
  output logic [DATA_WIDTH-1:0]                    m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]                  m_axis_tkeep,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic                                     m_axis_tlast,
  output logic [31:0]                              pkt_cnt,
  output logic                                     busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [103:0] tuple;
  logic [12:0]  beat, last_beat, nx_last;
  logic [3:0]   last_bytes, nx_bytes;
  logic [31:0]  seq;
  logic [15:0]  len;
  logic         fire, done;
  // entry decode: clamp length, derive final beat index and bytes in the final beat
  always_comb begin
    len      = fifo_data_in[15:0] < 16'(MIN_PKT_LEN) ? 16'(MIN_PKT_LEN) : fifo_data_in[15:0];
    nx_last  = 13'((({1'b0, len} + 17'd7) >> 3) - 17'd1);
    nx_bytes = len[2:0] == 3'd0 ? 4'd8 : {1'b0, len[2:0]};
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next state: a pop always (re)starts a packet, otherwise stay until the last beat is accepted
  always_comb
    state_nx = fifo_rd_en ? SEND : (state == SEND && !done) ? SEND : IDLE;
  // outputs: beat content is a pure function of latched entry and beat index, so it holds under stall
  always_comb begin
    m_axis_tvalid = state == SEND;
    busy          = m_axis_tvalid;
    m_axis_tlast  = m_axis_tvalid && beat == last_beat;
    fire          = m_axis_tvalid && m_axis_tready;
    done          = fire && m_axis_tlast;
    fifo_rd_en    = !reset && enable && !fifo_empty && (state == IDLE || done);
    m_axis_tkeep  = !m_axis_tvalid ? 8'h00 : m_axis_tlast ? ~(8'hFF >> last_bytes) : 8'hFF;
    m_axis_tdata  = !m_axis_tvalid ? 64'h0 :
                    beat == 13'd0 ? tuple[103:40] :
                    beat == 13'd1 ? {tuple[39:0], 24'h0} : {seq, 19'h0, beat};
  end
  // datapath: latch entry on pop, advance beat on handshake, count completed packets
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt    <= '0;
      tuple      <= '0;
      beat       <= '0;
      last_beat  <= '0;
      last_bytes <= '0;
      seq        <= '0;
    end else begin
      if (done) pkt_cnt <= pkt_cnt + 32'd1;
      if (fifo_rd_en) begin
        tuple      <= fifo_data_in[119:16];
        last_beat  <= nx_last;
        last_bytes <= nx_bytes;
        seq        <= done ? pkt_cnt + 32'd1 : pkt_cnt;
        beat       <= '0;
      end else if (fire) begin
        beat <= beat + 13'd1;
      end
    end
  end
endmodule

// File: tb/tb_outqueue_pkt_gen.sv
// tb_outqueue_pkt_gen: directed bench with a queue-based packet model checked every cycle
module tb_outqueue_pkt_gen;
  logic         clk = 0, reset = 1, enable = 0, fifo_empty = 1, m_axis_tready = 1;
  logic [119:0] fifo_data_in = '0;
  logic         fifo_rd_en, m_axis_tvalid, m_axis_tlast, busy;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic [31:0]  pkt_cnt;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  logic [119:0] fq[$];
  beat_t        exp_q[$];
  beat_t        hs[$];
  int           hs_cyc[$];
  int           n_cmp = 0, n_bad = 0, cyc = 0, b = 0;
  logic [31:0]  mcnt = 0;
  logic         stalled = 0;
  beat_t        held;
  localparam logic [103:0] TA = 104'hA0A1A2A3A4A5A6A7A8A9AAABAC;
  localparam logic [103:0] TB = 104'h0102030405060708090A0B0C0D;
  localparam logic [103:0] TC = 104'h1111222233334444555566667;
  localparam logic [103:0] TD = 104'hDEADBEEFCAFEF00D123456789;

  always #5 clk = ~clk;

  outqueue_pkt_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_data_in(fifo_data_in),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // expected beats of one packet, built from byte counts rather than beat counters
  function automatic void gen(input logic [119:0] e, input logic [31:0] seq);
    logic [103:0] t;
    int L, n, by;
    beat_t bt;
    t = e[119:16];
    L = int'(e[15:0]);
    if (L < 16) L = 16;
    n = (L + 7) / 8;
    for (int k = 0; k < n; k++) begin
      by = L - 8 * k;
      if (by > 8) by = 8;
      bt.d = k == 0 ? t[103:40] : k == 1 ? {t[39:0], 24'h0} : {seq, 32'(k)};
      bt.k = '0;
      for (int i = 0; i < by; i++) bt.k[7-i] = 1'b1;
      bt.l = k == n - 1;
      exp_q.push_back(bt);
    end
  endfunction

  // model update at each active edge, then refresh the FIFO head seen by the DUT
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      mcnt = 0;
      stalled = 0;
    end else begin
      stalled = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        hs.push_back(held);
        hs_cyc.push_back(cyc);
        if (exp_q.size() > 0) begin
          if (exp_q[0].l) mcnt++;
          void'(exp_q.pop_front());
        end
      end
      if (fifo_rd_en && fq.size() > 0) gen(fq.pop_front(), mcnt);
    end
    #2;
    fifo_empty = fq.size() == 0;
    fifo_data_in = fq.size() > 0 ? fq[0] : '0;
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("tvalid", m_axis_tvalid, exp_q.size() > 0);
      chk("busy", busy, exp_q.size() > 0);
      chk("pkt_cnt", pkt_cnt, mcnt);
      chk("rd_when_empty", fifo_rd_en & fifo_empty, 0);
      if (m_axis_tvalid && exp_q.size() > 0) begin
        chk("tdata", m_axis_tdata, exp_q[0].d);
        chk("tkeep", m_axis_tkeep, exp_q[0].k);
        chk("tlast", m_axis_tlast, exp_q[0].l);
      end
      if (stalled) begin
        chk("hold_tdata", m_axis_tdata, held.d);
        chk("hold_tkeep", m_axis_tkeep, held.k);
        chk("hold_tlast", m_axis_tlast, held.l);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push(input logic [103:0] t, input logic [15:0] l);
    fq.push_back({t, l});
    fifo_empty = 0;
    fifo_data_in = fq[0];
  endtask

  task automatic drain(input int maxc, input bit rnd);
    int c = 0;
    while ((exp_q.size() > 0 || fq.size() > 0) && c < maxc) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    m_axis_tready = 1;
    step();
    chk("drain_timeout", c < maxc, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    repeat (3) step();
    reset = 0;
    step();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    // 64 bytes, held off by enable first
    push(TA, 16'd64);
    repeat (3) step();
    chk("no_pop_disabled", fq.size(), 1);
    enable = 1;
    b = hs.size();
    drain(100, 0);
    chk("t1_beats", hs.size() - b, 8);
    chk("t1_beat0", hs[b].d, 64'hA0A1A2A3A4A5A6A7);
    chk("t1_beat1", hs[b+1].d, 64'hA8A9AAABAC000000);
    chk("t1_beat2", hs[b+2].d, 64'h0000000000000002);
    chk("t1_last_keep", hs[b+7].k, 8'hFF);
    chk("t1_last", hs[b+7].l, 1);
    chk("t1_cnt", pkt_cnt, 1);
    // 21 bytes
    push(TB, 16'd21);
    b = hs.size();
    drain(100, 0);
    chk("t2_beats", hs.size() - b, 3);
    chk("t2_beat2", hs[b+2].d, 64'h0000000100000002);
    chk("t2_keep", hs[b+2].k, 8'hF8);
    chk("t2_last", hs[b+2].l, 1);
    chk("t2_cnt", pkt_cnt, 2);
    // short lengths clamp to 16 bytes
    push(TC, 16'd5);
    push(TD, 16'd0);
    b = hs.size();
    drain(100, 0);
    chk("t3_beats", hs.size() - b, 4);
    chk("t3_keep_a", hs[b+1].k, 8'hFF);
    chk("t3_last_a", hs[b+1].l, 1);
    chk("t3_keep_b", hs[b+3].k, 8'hFF);
    chk("t3_cnt", pkt_cnt, 4);
    // back-to-back packets with no idle gap
    do_reset();
    push(TA, 16'd24);
    push(TB, 16'd24);
    push(TC, 16'd24);
    b = hs.size();
    drain(100, 0);
    chk("t4_beats", hs.size() - b, 9);
    chk("t4_seq0", hs[b+2].d, 64'h0000000000000002);
    chk("t4_seq1", hs[b+5].d, 64'h0000000100000002);
    chk("t4_seq2", hs[b+8].d, 64'h0000000200000002);
    chk("t4_gap1", hs_cyc[b+3] - hs_cyc[b+2], 1);
    chk("t4_gap2", hs_cyc[b+6] - hs_cyc[b+5], 1);
    chk("t4_beat0_b", hs[b+3].d, 64'h0102030405060708);
    chk("t4_cnt", pkt_cnt, 3);
    // random backpressure, 100 bytes
    push(TD, 16'd100);
    b = hs.size();
    drain(400, 1);
    chk("t5_beats", hs.size() - b, 13);
    chk("t5_last_keep", hs[b+12].k, 8'hF0);
    chk("t5_last", hs[b+12].l, 1);
    chk("t5_beat12", hs[b+12].d, 64'h000000030000000C);
    chk("t5_cnt", pkt_cnt, 4);
    // enable dropped mid-packet: packet completes, next entry stays queued
    push(TA, 16'd40);
    push(TB, 16'd16);
    step();
    step();
    enable = 0;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
    repeat (4) step();
    chk("en_left_queued", fq.size(), 1);
    chk("en_cnt", pkt_cnt, 5);
    chk("en_idle", m_axis_tvalid, 0);
    enable = 1;
    drain(100, 0);
    chk("en_cnt2", pkt_cnt, 6);
    // reset in the middle of a packet
    push(TA, 16'd64);
    push(TB, 16'd24);
    b = hs.size();
    for (int c = 0; c < 50 && hs.size() - b < 3; c++) step();
    chk("t6_at_beat3", hs.size() - b, 3);
    reset = 1;
    step();
    reset = 0;
    chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_cnt", pkt_cnt, 0);
    chk("t6_busy", busy, 0);
    b = hs.size();
    drain(100, 0);
    chk("t6_beats", hs.size() - b, 3);
    chk("t6_beat0", hs[b].d, 64'h0102030405060708);
    chk("t6_beat2", hs[b+2].d, 64'h0000000000000002);
    chk("t6_cnt2", pkt_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
